// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, digit adjust constants and BCD bus width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD = 4'd3;

  // Width of the packed BCD bus for a given number of digits
  function automatic int bcd_width(input int digits);
    return DIGIT_W * digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit "add 3" correction used by the shift-and-add-3 converter.
// A digit of 5 or more would become 10 or more after the next shift, so it
// is pre-biased by 3 to make the shift carry into the next digit instead.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Pre-shift correction of one BCD digit
  always_comb begin
    digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_ADD : digit_in;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a start/done
// handshake. One bit is shifted per clock; bcd/ovf/neg are registered and
// held between conversions so the 7-segment drivers see a stable value.
// Optional build macro: BCD_SIGNED_INPUT_EN treats bin as two's complement,
// converts its magnitude and reports the sign on neg. Without it bin is
// unsigned and neg stays 0.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                                  CLOCK_50,
  input  logic                                  RST,
  input  logic                                  start,
  input  logic [WIDTH-1:0]                      bin,
  output logic                                  busy,
  output logic                                  done,
  output logic [bcd_pkg::bcd_width(DIGITS)-1:0] bcd,
  output logic                                  ovf,
  output logic                                  neg
);

  localparam int BW = bcd_width(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] bin_work;
  logic [BW-1:0]    bcd_work;
  logic             ovf_work;
  logic             sign_work;
  logic [CW-1:0]    count;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_next;
  logic [WIDTH-1:0] bin_next;
  logic             ovf_next;

  logic [WIDTH-1:0] load_mag;
  logic             load_sign;

  // One adjust cell per digit of the working register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (bcd_work[g*DIGIT_W +: DIGIT_W]),
      .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted digits shift left by one; the bit leaving the top digit is overflow
  always_comb begin
    {bcd_next, bin_next} = {bcd_adj, bin_work} << 1;
    ovf_next = ovf_work | bcd_adj[BW-1];
  end

  // Operand conditioning at accept time: magnitude and sign of bin
`ifdef BCD_SIGNED_INPUT_EN
  always_comb begin
    load_sign = bin[WIDTH-1];
    load_mag  = load_sign ? -bin : bin;
  end
`else
  always_comb begin
    load_sign = 1'b0;
    load_mag  = bin;
  end
`endif

  // Handshake FSM and conversion datapath with registered outputs
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
      bin_work  <= '0;
      bcd_work  <= '0;
      ovf_work  <= 1'b0;
      sign_work <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bin_work  <= load_mag;
            bcd_work  <= '0;
            ovf_work  <= 1'b0;
            sign_work <= load_sign;
            count     <= CW'(WIDTH);
            busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_next;
          bin_work <= bin_next;
          ovf_work <= ovf_next;
          count    <= count - CW'(1);
          if (count == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= bcd_next;
            ovf   <= ovf_next;
            neg   <= sign_work;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter. Two instances run side by side
// on the same stimulus: the default 3-digit build and a 2-digit build that
// exercises overflow. Expected values come from a decimal reference model.
// Honours BCD_SIGNED_INPUT_EN the same way the design does.
module tb_bcd_seq_converter;

  logic        CLOCK_50;
  logic        RST;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done, ovf, neg;
  logic [11:0] bcd;
  logic        busy2, done2, ovf2, neg2;
  logic [7:0]  bcd2;

  int total_checks = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .ovf      (ovf),
    .neg      (neg)
  );

  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .start    (start),
    .bin      (bin),
    .busy     (busy2),
    .done     (done2),
    .bcd      (bcd2),
    .ovf      (ovf2),
    .neg      (neg2)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Decimal reference: sign/magnitude of the operand, then digits by div/mod
  function automatic void model(input logic [7:0] b, input int digits,
                                output logic [11:0] exp_bcd,
                                output logic exp_ovf, output logic exp_neg);
    int v;
    v = int'(b);
    exp_neg = 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
    if (b[7]) begin
      v = 256 - int'(b);
      exp_neg = 1'b1;
    end
`endif
    exp_ovf = (v > (10 ** digits) - 1);
    exp_bcd = '0;
    for (int i = 0; i < digits; i++) begin
      exp_bcd = exp_bcd | 12'((v % 10) << (4 * i));
      v = v / 10;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One conversion from IDLE; optionally pokes start with bin=42 mid-shift
  task automatic applyStimulus(input logic [7:0] value, input bit poke);
    int lat;
    int busy_cnt;
    logic [11:0] e3, e2;
    logic eo3, eo2, en3, en2;
    model(value, 3, e3, eo3, en3);
    model(value, 2, e2, eo2, en2);
    bin = value;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    bin = 8'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (poke && lat == 3) begin
        start = 1'b1;
        bin = 8'd42;
      end else begin
        start = 1'b0;
      end
      @(posedge CLOCK_50); #1;
      lat++;
    end
    start = 1'b0;
    checkOutput($sformatf("latency_%0d", value), lat, 8);
    checkOutput($sformatf("busy_cycles_%0d", value), busy_cnt, 8);
    checkOutput($sformatf("busy_at_done_%0d", value), busy, 0);
    checkOutput($sformatf("bcd_%0d", value), bcd, e3);
    checkOutput($sformatf("ovf_%0d", value), ovf, eo3);
    checkOutput($sformatf("neg_%0d", value), neg, en3);
    checkOutput($sformatf("done2_%0d", value), done2, 1);
    checkOutput($sformatf("bcd2_%0d", value), bcd2, e2);
    checkOutput($sformatf("ovf2_%0d", value), ovf2, eo2);
    @(posedge CLOCK_50); #1;
    checkOutput($sformatf("done_pulse_%0d", value), done, 0);
    checkOutput($sformatf("bcd_hold_%0d", value), bcd, e3);
    checkOutput($sformatf("ovf_hold_%0d", value), ovf, eo3);
  endtask

  initial begin
    int n;
    logic [11:0] e3;
    logic eo3, en3;
    logic [7:0] directed [9] = '{8'd0, 8'd255, 8'd9, 8'd200, 8'd99,
                                 8'hF3, 8'h80, 8'd1, 8'd100};

    RST = 1'b1;
    start = 1'b0;
    bin = 8'd0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bcd", bcd, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_neg", neg, 0);
    @(negedge CLOCK_50);
    RST = 1'b0;
    @(posedge CLOCK_50); #1;

    foreach (directed[i]) applyStimulus(directed[i], 1'b0);

    $display("[TB] start pulse during shift must be ignored");
    applyStimulus(8'd137, 1'b1);

    $display("[TB] back-to-back with start held high");
    start = 1'b1;
    bin = 8'd137;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin
        @(posedge CLOCK_50); #1;
        n++;
      end while (!done && n < 40);
      checkOutput($sformatf("b2b_period_%0d", r), n, 9);
      checkOutput($sformatf("b2b_bcd_%0d", r), bcd, 12'h137);
    end
    start = 1'b0;
    @(posedge CLOCK_50); #1;

    $display("[TB] asynchronous reset mid-conversion");
    bin = 8'd200;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_done", done, 0);
    checkOutput("async_rst_bcd", bcd, 0);
    checkOutput("async_rst_bcd2", bcd2, 0);
    @(negedge CLOCK_50);
    RST = 1'b0;
    @(posedge CLOCK_50); #1;
    checkOutput("post_rst_idle", busy, 0);
    applyStimulus(8'd77, 1'b0);
    model(8'd77, 3, e3, eo3, en3);
    checkOutput("after_rst_bcd_77", bcd, e3);

    $display("[TB] random operands");
    for (int k = 0; k < 16; k++) applyStimulus(8'($urandom_range(0, 255)), 1'b0);

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
